alu_cmd_seq: RTL and testbench

Byte-stream command sequencer that sits directly in front of the 8-bit ALU and captures its output.
- Accepts packets of opcode, operand A and (for binary ops) operand B over a valid/ready byte interface.
- Drives the ALU opcode/in_a/in_b inputs from registers and samples the combinational ALU result and flags.
- Presents the captured result on a valid/ready result interface.
- Counts completed commands.

---
 rtl/alu_cmd_seq.sv | 172 +++++++++++++++++
 tb/tb_alu_cmd_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_seq.sv
// Byte-stream command sequencer in front of an 8-bit ALU: collects opcode/operand
// packets, drives the ALU inputs from registers and captures the result for a consumer.
module alu_cmd_seq #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OP_W   = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [OP_W-1:0]   op_out,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero_in,
    input  logic              alu_carry_in,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic              res_carry,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy,
    output logic              err_illegal,
    output logic [CNT_W-1:0]  cmd_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GET_A = 3'd1,
        S_GET_B = 3'd2,
        S_EXEC  = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [OP_W-1:0]   r_op, w_op_nxt;
    logic [DATA_W-1:0] r_a, w_a_nxt;
    logic [DATA_W-1:0] r_b, w_b_nxt;
    logic [DATA_W-1:0] r_res, w_res_nxt;
    logic              r_zero, w_zero_nxt;
    logic              r_carry, w_carry_nxt;
    logic              r_res_valid, w_res_valid_nxt;
    logic              r_err, w_err_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_byte_ready, w_byte_ready_nxt;
    logic              r_busy, w_busy_nxt;
    logic              w_xfer;
    logic [OP_W-1:0]   w_opc;

    function automatic logic f_is_binary(input logic [OP_W-1:0] op);
        return (op == OP_W'(1)) || (op == OP_W'(2)) || (op == OP_W'(5)) ||
               (op == OP_W'(6)) || (op == OP_W'(7));
    endfunction

    function automatic logic f_is_unary(input logic [OP_W-1:0] op);
        return (op == OP_W'(3)) || (op == OP_W'(4)) || (op == OP_W'(8)) ||
               (op == OP_W'(9)) || (op == OP_W'(10)) || (op == OP_W'(11));
    endfunction

    assign w_xfer = byte_valid & r_byte_ready;
    assign w_opc  = byte_in[OP_W-1:0];

    // Next-state and datapath update; ALU outputs are only sampled while in EXEC.
    always_comb begin
        w_state_nxt     = r_state;
        w_op_nxt        = r_op;
        w_a_nxt         = r_a;
        w_b_nxt         = r_b;
        w_res_nxt       = r_res;
        w_zero_nxt      = r_zero;
        w_carry_nxt     = r_carry;
        w_res_valid_nxt = r_res_valid;
        w_err_nxt       = 1'b0;
        w_cnt_nxt       = r_cnt;

        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    if (f_is_binary(w_opc) || f_is_unary(w_opc)) begin
                        w_op_nxt    = w_opc;
                        w_state_nxt = S_GET_A;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_GET_A: begin
                if (w_xfer) begin
                    w_a_nxt = byte_in;
                    if (f_is_unary(r_op)) begin
                        w_b_nxt     = '0;
                        w_state_nxt = S_EXEC;
                    end else begin
                        w_state_nxt = S_GET_B;
                    end
                end
            end
            S_GET_B: begin
                if (w_xfer) begin
                    w_b_nxt     = byte_in;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_res_nxt       = alu_result;
                w_zero_nxt      = alu_zero_in;
                w_carry_nxt     = alu_carry_in;
                w_res_valid_nxt = 1'b1;
                w_state_nxt     = S_HOLD;
            end
            S_HOLD: begin
                if (res_ready) begin
                    w_res_valid_nxt = 1'b0;
                    w_cnt_nxt       = r_cnt + CNT_W'(1);
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_byte_ready_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_GET_A) ||
                           (w_state_nxt == S_GET_B);
        w_busy_nxt       = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_res        <= '0;
            r_zero       <= 1'b0;
            r_carry      <= 1'b0;
            r_res_valid  <= 1'b0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
            r_byte_ready <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_op         <= w_op_nxt;
            r_a          <= w_a_nxt;
            r_b          <= w_b_nxt;
            r_res        <= w_res_nxt;
            r_zero       <= w_zero_nxt;
            r_carry      <= w_carry_nxt;
            r_res_valid  <= w_res_valid_nxt;
            r_err        <= w_err_nxt;
            r_cnt        <= w_cnt_nxt;
            r_byte_ready <= w_byte_ready_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    assign byte_ready  = r_byte_ready;
    assign busy        = r_busy;
    assign op_out      = r_op;
    assign a_out       = r_a;
    assign b_out       = r_b;
    assign res_data    = r_res;
    assign res_zero    = r_zero;
    assign res_carry   = r_carry;
    assign res_valid   = r_res_valid;
    assign err_illegal = r_err;
    assign cmd_count   = r_cnt;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Bench for alu_cmd_seq: behavioural ALU stub plus packet-level reference model,
// directed scenarios followed by randomized command traffic.
module tb_alu_cmd_seq;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned CNT_W  = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic [DATA_W-1:0] byte_in = '0;
    logic              byte_valid = 1'b0;
    logic              byte_ready;
    logic [OP_W-1:0]   op_out;
    logic [DATA_W-1:0] a_out, b_out;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero_in, alu_carry_in;
    logic [DATA_W-1:0] res_data;
    logic              res_zero, res_carry, res_valid;
    logic              res_ready = 1'b0;
    logic              busy, err_illegal;
    logic [CNT_W-1:0]  cmd_count;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_count = 8'h00;

    always #5 clk = ~clk;

    alu_cmd_seq #(.DATA_W(DATA_W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .op_out(op_out), .a_out(a_out), .b_out(b_out),
        .alu_result(alu_result), .alu_zero_in(alu_zero_in), .alu_carry_in(alu_carry_in),
        .res_data(res_data), .res_zero(res_zero), .res_carry(res_carry),
        .res_valid(res_valid), .res_ready(res_ready), .busy(busy),
        .err_illegal(err_illegal), .cmd_count(cmd_count)
    );

    // Returns {zero, carry, result[7:0]} for an 8-bit ALU operation.
    function automatic logic [9:0] ref_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int unsigned ua, ub, r;
        logic c;
        ua = a; ub = b; r = 0; c = 1'b0;
        case (op)
            4'h1: begin r = ua + ub; c = (r > 255); end
            4'h2: begin r = (ua + 256 - ub) % 256; c = (ua < ub); end
            4'h3: begin r = ua + 1; c = (ua == 255); end
            4'h4: begin r = (ua + 255) % 256; c = (ua == 0); end
            4'h5: r = ua | ub;
            4'h6: r = ua & ub;
            4'h7: r = ua ^ ub;
            4'h8: begin r = ua / 2; c = ((ua % 2) == 1); end
            4'h9: begin r = ua * 2; c = (ua >= 128); end
            4'hA: r = 255 - ua;
            4'hB: begin r = (256 - ua) % 256; c = (ua != 0); end
            default: r = 0;
        endcase
        r = r % 256;
        return {(r == 0), c, 8'(r)};
    endfunction

    function automatic logic is_bin(input logic [3:0] op);
        return op inside {4'h1, 4'h2, 4'h5, 4'h6, 4'h7};
    endfunction

    function automatic logic is_un(input logic [3:0] op);
        return op inside {4'h3, 4'h4, 4'h8, 4'h9, 4'hA, 4'hB};
    endfunction

    // ALU stub; outputs are corrupted whenever a result is being presented so that
    // any capture outside the execute cycle shows up as a changed result.
    logic [9:0] w_alu;
    assign w_alu        = ref_alu(op_out, a_out, b_out);
    assign alu_result   = w_alu[7:0] ^ (res_valid ? 8'hA5 : 8'h00);
    assign alu_carry_in = w_alu[8] ^ res_valid;
    assign alu_zero_in  = w_alu[9] ^ res_valid;

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (!byte_ready) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                $display("FAIL send_byte: byte_ready stuck at %b for 100 cycles, required 1", byte_ready);
                $fatal(1, "bench stopped");
            end
        end
        byte_in = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
        byte_in = 8'($urandom);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!res_valid) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                $display("FAIL wait_valid: res_valid stuck at %b for 100 cycles, required 1", res_valid);
                $fatal(1, "bench stopped");
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if ({op_out, a_out, b_out, res_data, res_zero, res_carry, res_valid, err_illegal, cmd_count, busy} !== 46'h0)
            begin failures++; $display("FAIL reset_vals: got op=%h a=%h b=%h res=%h z=%b c=%b v=%b err=%b cnt=%h busy=%b, required all 0", op_out, a_out, b_out, res_data, res_zero, res_carry, res_valid, err_illegal, cmd_count, busy); end
        @(negedge clk);
        reset_n = 1'b1;
        exp_count = 8'h00;
        @(negedge clk);
        checks++; if ({byte_ready, busy, res_valid} !== 3'b100)
            begin failures++; $display("FAIL reset_release: got ready/busy/valid=%b required 100", {byte_ready, busy, res_valid}); end
    endtask

    task automatic test_add();
        res_ready = 1'b1;
        send_byte(8'h01); send_byte(8'h3C); send_byte(8'h05);
        checks++; if ({op_out, a_out, b_out} !== {4'h1, 8'h3C, 8'h05})
            begin failures++; $display("FAIL add_exec_inputs: got %h/%h/%h required 1/3c/05", op_out, a_out, b_out); end
        checks++; if ({res_valid, byte_ready, busy} !== 3'b001)
            begin failures++; $display("FAIL add_exec_status: got valid/ready/busy=%b required 001", {res_valid, byte_ready, busy}); end
        @(negedge clk);
        checks++; if ({res_valid, res_data, res_zero, res_carry} !== {1'b1, 8'h41, 1'b0, 1'b0})
            begin failures++; $display("FAIL add_result: got v=%b d=%h z=%b c=%b required 1/41/0/0", res_valid, res_data, res_zero, res_carry); end
        @(negedge clk);
        exp_count++;
        checks++; if ({res_valid, res_data, cmd_count} !== {1'b0, 8'h41, exp_count})
            begin failures++; $display("FAIL add_done: got v=%b d=%h cnt=%h required 0/41/%h", res_valid, res_data, cmd_count, exp_count); end
    endtask

    task automatic test_unary_backpressure();
        res_ready = 1'b0;
        send_byte(8'h09); send_byte(8'h80);
        checks++; if ({op_out, a_out, b_out} !== {4'h9, 8'h80, 8'h00})
            begin failures++; $display("FAIL shl_exec_inputs: got %h/%h/%h required 9/80/00", op_out, a_out, b_out); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if ({res_valid, byte_ready, res_data, res_zero, res_carry} !== {1'b1, 1'b0, 8'h00, 1'b1, 1'b1})
                begin failures++; $display("FAIL shl_hold[%0d]: got v=%b rdy=%b d=%h z=%b c=%b required 1/0/00/1/1", i, res_valid, byte_ready, res_data, res_zero, res_carry); end
        end
        res_ready = 1'b1;
        @(negedge clk);
        exp_count++;
        checks++; if ({res_valid, cmd_count} !== {1'b0, exp_count})
            begin failures++; $display("FAIL shl_release: got v=%b cnt=%h required 0/%h", res_valid, cmd_count, exp_count); end
    endtask

    task automatic test_illegal();
        send_byte(8'h0C);
        checks++; if ({err_illegal, busy, op_out} !== {1'b1, 1'b0, 4'h9})
            begin failures++; $display("FAIL illegal_pulse: got err=%b busy=%b op=%h required 1/0/9", err_illegal, busy, op_out); end
        @(negedge clk);
        checks++; if ({err_illegal, busy} !== 2'b00)
            begin failures++; $display("FAIL illegal_after: got err=%b busy=%b required 0/0", err_illegal, busy); end
        send_byte(8'h02); send_byte(8'h10); send_byte(8'h20);
        wait_valid();
        checks++; if ({res_data, res_zero, res_carry} !== {8'hF0, 1'b0, 1'b1})
            begin failures++; $display("FAIL sub_result: got d=%h z=%b c=%b required f0/0/1", res_data, res_zero, res_carry); end
        @(negedge clk);
        exp_count++;
        checks++; if ({res_valid, cmd_count} !== {1'b0, exp_count})
            begin failures++; $display("FAIL sub_done: got v=%b cnt=%h required 0/%h", res_valid, cmd_count, exp_count); end
    endtask

    task automatic test_stall();
        send_byte(8'h06);
        for (int i = 0; i < 3; i++) begin
            checks++; if ({busy, byte_ready, res_valid} !== 3'b110)
                begin failures++; $display("FAIL stall_get_a[%0d]: got busy/rdy/v=%b required 110", i, {busy, byte_ready, res_valid}); end
            @(negedge clk);
        end
        send_byte(8'hF0);
        for (int i = 0; i < 2; i++) begin
            checks++; if ({busy, byte_ready, res_valid} !== 3'b110)
                begin failures++; $display("FAIL stall_get_b[%0d]: got busy/rdy/v=%b required 110", i, {busy, byte_ready, res_valid}); end
            @(negedge clk);
        end
        send_byte(8'h0F);
        wait_valid();
        checks++; if ({res_data, res_zero, res_carry} !== {8'h00, 1'b1, 1'b0})
            begin failures++; $display("FAIL and_result: got d=%h z=%b c=%b required 00/1/0", res_data, res_zero, res_carry); end
        @(negedge clk);
        exp_count++;
        checks++; if (cmd_count !== exp_count)
            begin failures++; $display("FAIL and_count: got %h required %h", cmd_count, exp_count); end
    endtask

    task automatic test_reset_mid();
        send_byte(8'h07); send_byte(8'hAA);
        reset_n = 1'b0;
        #1;
        checks++; if ({op_out, a_out, b_out, res_data, res_zero, res_carry, res_valid, err_illegal, cmd_count, busy} !== 46'h0)
            begin failures++; $display("FAIL midreset_vals: got op=%h a=%h b=%h res=%h v=%b cnt=%h busy=%b, required all 0", op_out, a_out, b_out, res_data, res_valid, cmd_count, busy); end
        @(negedge clk);
        reset_n = 1'b1;
        exp_count = 8'h00;
        @(negedge clk);
        checks++; if ({byte_ready, busy} !== 2'b10)
            begin failures++; $display("FAIL midreset_ready: got rdy/busy=%b required 10", {byte_ready, busy}); end
        send_byte(8'h03); send_byte(8'hFF);
        wait_valid();
        checks++; if ({res_data, res_zero, res_carry} !== {8'h00, 1'b1, 1'b1})
            begin failures++; $display("FAIL inc_ff_result: got d=%h z=%b c=%b required 00/1/1", res_data, res_zero, res_carry); end
        @(negedge clk);
        exp_count++;
        checks++; if (cmd_count !== exp_count)
            begin failures++; $display("FAIL inc_ff_count: got %h required %h", cmd_count, exp_count); end
        // A result waiting for the consumer is dropped by reset.
        res_ready = 1'b0;
        send_byte(8'h01); send_byte(8'h01); send_byte(8'h02);
        wait_valid();
        reset_n = 1'b0;
        #1;
        checks++; if ({res_valid, cmd_count, res_data} !== 17'h0)
            begin failures++; $display("FAIL holdreset: got v=%b cnt=%h d=%h required 0/00/00", res_valid, cmd_count, res_data); end
        @(negedge clk);
        reset_n = 1'b1;
        exp_count = 8'h00;
        res_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [7:0] a;
        logic [9:0] r;
        res_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            a = 8'($urandom);
            r = ref_alu(4'h3, a, 8'h00);
            send_byte(8'h03); send_byte(a);
            wait_valid();
            checks++; if ({res_zero, res_carry, res_data} !== r)
                begin failures++; $display("FAIL wrap_result[%0d]: got %h required %h", i, {res_zero, res_carry, res_data}, r); end
            @(negedge clk);
            exp_count++;
            checks++; if ({res_valid, cmd_count} !== {1'b0, exp_count})
                begin failures++; $display("FAIL wrap_count[%0d]: got v=%b cnt=%h required 0/%h", i, res_valid, cmd_count, exp_count); end
        end
        checks++; if (cmd_count !== 8'h00)
            begin failures++; $display("FAIL wrap_zero: got %h required 00", cmd_count); end
    endtask

    task automatic test_random();
        logic [3:0] op;
        logic [7:0] a, b, exp_b;
        logic [9:0] r;
        int hold;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom);
            a = 8'($urandom);
            b = 8'($urandom);
            hold = int'($urandom_range(0, 3));
            res_ready = (hold == 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte({4'($urandom), op});
            if (!is_bin(op) && !is_un(op)) begin
                checks++; if ({err_illegal, busy} !== 2'b10)
                    begin failures++; $display("FAIL rnd_illegal[%0d] op=%h: got err=%b busy=%b required 1/0", i, op, err_illegal, busy); end
                continue;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(a);
            if (is_bin(op)) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_byte(b);
            end
            exp_b = is_bin(op) ? b : 8'h00;
            r = ref_alu(op, a, exp_b);
            wait_valid();
            checks++; if ({op_out, a_out, b_out, res_zero, res_carry, res_data} !== {op, a, exp_b, r})
                begin failures++; $display("FAIL rnd_result[%0d]: got op=%h a=%h b=%h zcd=%h required %h/%h/%h/%h", i, op_out, a_out, b_out, {res_zero, res_carry, res_data}, op, a, exp_b, r); end
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                checks++; if ({res_valid, res_zero, res_carry, res_data} !== {1'b1, r})
                    begin failures++; $display("FAIL rnd_hold[%0d.%0d]: got v=%b zcd=%h required 1/%h", i, h, res_valid, {res_zero, res_carry, res_data}, r); end
            end
            res_ready = 1'b1;
            @(negedge clk);
            exp_count++;
            checks++; if ({res_valid, cmd_count} !== {1'b0, exp_count})
                begin failures++; $display("FAIL rnd_done[%0d]: got v=%b cnt=%h required 0/%h", i, res_valid, cmd_count, exp_count); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_unary_backpressure();
        test_illegal();
        test_stall();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
